// File: rtl/hazard_forward_unit_if.sv
// Signal bundle between the EX-stage pipeline control and the hazard/forwarding unit.
// Every signal is a level that is valid every cycle; there is no valid/ready handshake.
interface hazard_forward_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] RS1_ID;
    logic [REG_ADDR_W-1:0] RS2_ID;
    logic [REG_ADDR_W-1:0] RS1_EX;
    logic [REG_ADDR_W-1:0] RS2_EX;
    logic [REG_ADDR_W-1:0] RD_EX;
    logic                  RegWrite_EX;
    logic                  MemRead_EX;
    logic                  Branch_EX;
    logic                  ZERO_EX;
    logic [1:0]            forwardA;
    logic [1:0]            forwardB;
    logic                  PC_write;
    logic                  IF_ID_write;
    logic                  IF_ID_flush;
    logic                  ID_EX_flush;
    logic                  stall_active;
    logic                  fsm_state;

    modport master (
        output RS1_ID, RS2_ID, RS1_EX, RS2_EX, RD_EX,
        output RegWrite_EX, MemRead_EX, Branch_EX, ZERO_EX,
        input  forwardA, forwardB, PC_write, IF_ID_write,
        input  IF_ID_flush, ID_EX_flush, stall_active, fsm_state
    );

    modport slave (
        input  RS1_ID, RS2_ID, RS1_EX, RS2_EX, RD_EX,
        input  RegWrite_EX, MemRead_EX, Branch_EX, ZERO_EX,
        output forwardA, forwardB, PC_write, IF_ID_write,
        output IF_ID_flush, ID_EX_flush, stall_active, fsm_state
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX-stage forwarding select, load-use stall and taken-branch flush control for the
// 5-stage core. Keeps its own MEM/WB shadow copies of the destination registers.
module hazard_forward_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_forward_unit_if.slave hf
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;
    localparam int         CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);

    logic [0:0]            state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [REG_ADDR_W-1:0] rd_mem, rd_wb;
    logic                  rw_mem, rw_wb, ld_mem;

    logic hz, bt;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, stall_active;

    // Shadow pipeline keeps capturing EX even when ID/EX is flushed; the bubble
    // reaches these registers one cycle later with its control bits cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_mem <= '0;
            rw_mem <= 1'b0;
            ld_mem <= 1'b0;
            rd_wb  <= '0;
            rw_wb  <= 1'b0;
        end else begin
            rd_mem <= hf.RD_EX;
            rw_mem <= hf.RegWrite_EX;
            ld_mem <= hf.MemRead_EX;
            rd_wb  <= rd_mem;
            rw_wb  <= rw_mem;
        end
    end

    // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
    assign hf.forwardA = (rw_mem && rd_mem != '0 && rd_mem == hf.RS1_EX) ? 2'b10 :
                         (rw_wb  && rd_wb  != '0 && rd_wb  == hf.RS1_EX) ? 2'b01 : 2'b00;
    assign hf.forwardB = (rw_mem && rd_mem != '0 && rd_mem == hf.RS2_EX) ? 2'b10 :
                         (rw_wb  && rd_wb  != '0 && rd_wb  == hf.RS2_EX) ? 2'b01 : 2'b00;

    assign hz = hf.MemRead_EX && (hf.RD_EX != '0) &&
                ((hf.RD_EX == hf.RS1_ID) || (hf.RD_EX == hf.RS2_ID));
    assign bt = hf.Branch_EX && hf.ZERO_EX;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        stall_active = 1'b0;
        case (state)
            ST_RUN: begin
                if (bt) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (hz) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    cnt_nx      = CNT_INIT;
                    if (LOAD_STALL_CYCLES > 1) state_nx = ST_STALL;
                end
            end
            ST_STALL: begin
                // EX holds a bubble here, so a branch indication cannot be genuine.
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_flush  = 1'b1;
                stall_active = 1'b1;
                cnt_nx       = cnt - 1'b1;
                if (cnt <= 1) state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign hf.PC_write     = pc_write;
    assign hf.IF_ID_write  = if_id_write;
    assign hf.IF_ID_flush  = if_id_flush;
    assign hf.ID_EX_flush  = id_ex_flush;
    assign hf.stall_active = stall_active;
    assign hf.fsm_state    = state;

    logic unused_ld;
    assign unused_ld = ld_mem;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (1 and 3 stall cycles) share random and
// directed stimulus; a reference model fills an expected queue that a monitor drains.
module tb_hazard_forward_unit;
  logic clk;
  logic reset;

  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex;
  logic       rw_ex, mr_ex, br_ex, z_ex;

  int compared = 0;
  int mismatched = 0;

  logic [17:0] exp_q[$];

  // model state: index 0 = instruction now in MEM, 1 = now in WB
  int   hist_rd[2];
  logic hist_rw[2];
  int   sl1;
  int   sl3;

  localparam logic [8:0] RESET_WORD = 9'b00_00_11000;

  hazard_forward_unit_if #(.REG_ADDR_W(5)) if1 ();
  hazard_forward_unit_if #(.REG_ADDR_W(5)) if3 ();

  assign if1.RS1_ID = rs1_id;
  assign if1.RS2_ID = rs2_id;
  assign if1.RS1_EX = rs1_ex;
  assign if1.RS2_EX = rs2_ex;
  assign if1.RD_EX = rd_ex;
  assign if1.RegWrite_EX = rw_ex;
  assign if1.MemRead_EX = mr_ex;
  assign if1.Branch_EX = br_ex;
  assign if1.ZERO_EX = z_ex;
  assign if3.RS1_ID = rs1_id;
  assign if3.RS2_ID = rs2_id;
  assign if3.RS1_EX = rs1_ex;
  assign if3.RS2_EX = rs2_ex;
  assign if3.RD_EX = rd_ex;
  assign if3.RegWrite_EX = rw_ex;
  assign if3.MemRead_EX = mr_ex;
  assign if3.Branch_EX = br_ex;
  assign if3.ZERO_EX = z_ex;

  hazard_forward_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .hf(if1)
  );
  hazard_forward_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .hf(if3)
  );

  wire [8:0] act1 = {if1.forwardA, if1.forwardB, if1.PC_write, if1.IF_ID_write,
                     if1.IF_ID_flush, if1.ID_EX_flush, if1.stall_active};
  wire [8:0] act3 = {if3.forwardA, if3.forwardB, if3.PC_write, if3.IF_ID_write,
                     if3.IF_ID_flush, if3.ID_EX_flush, if3.stall_active};

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got fA=%b fB=%b ctl=%b, expected fA=%b fB=%b ctl=%b (t=%0t)",
               name, got[8:7], got[6:5], got[4:0], want[8:7], want[6:5], want[4:0], $time);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, want, $time);
    end
  endtask

  // reference model
  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (rs != 0 && hist_rw[0] && hist_rd[0] == int'(rs)) return 2'b10;
    if (rs != 0 && hist_rw[1] && hist_rd[1] == int'(rs)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic cur_hz();
    return mr_ex && rd_ex != 0 && (rd_ex == rs1_id || rd_ex == rs2_id);
  endfunction

  function automatic logic cur_bt();
    return br_ex && z_ex;
  endfunction

  // ctl = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, stall_active}
  function automatic logic [8:0] exp_word(input int stall_left);
    logic [4:0] ctl;
    if (stall_left > 0) ctl = 5'b00011;
    else if (cur_bt()) ctl = 5'b11110;
    else if (cur_hz()) ctl = 5'b00010;
    else ctl = 5'b11000;
    return {fwd_model(rs1_ex), fwd_model(rs2_ex), ctl};
  endfunction

  function automatic int next_sl(input int sl, input int lsc);
    if (sl > 0) return sl - 1;
    if (!cur_bt() && cur_hz()) return lsc - 1;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      hist_rd[i] = 0;
      hist_rw[i] = 1'b0;
    end
    sl1 = 0;
    sl3 = 0;
  endtask

  task automatic set_in(input logic [4:0] a_rs1_id, input logic [4:0] a_rs2_id,
                        input logic [4:0] a_rs1_ex, input logic [4:0] a_rs2_ex,
                        input logic [4:0] a_rd, input logic a_rw, input logic a_mr,
                        input logic a_br, input logic a_z);
    rs1_id = a_rs1_id; rs2_id = a_rs2_id; rs1_ex = a_rs1_ex; rs2_ex = a_rs2_ex;
    rd_ex = a_rd; rw_ex = a_rw; mr_ex = a_mr; br_ex = a_br; z_ex = a_z;
  endtask

  // driver: apply one cycle of inputs, queue the expectation, advance the model
  task automatic drive(input logic [4:0] a_rs1_id, input logic [4:0] a_rs2_id,
                       input logic [4:0] a_rs1_ex, input logic [4:0] a_rs2_ex,
                       input logic [4:0] a_rd, input logic a_rw, input logic a_mr,
                       input logic a_br, input logic a_z);
    set_in(a_rs1_id, a_rs2_id, a_rs1_ex, a_rs2_ex, a_rd, a_rw, a_mr, a_br, a_z);
    exp_q.push_back({exp_word(sl1), exp_word(sl3)});
    @(posedge clk);
    sl1 = next_sl(sl1, 1);
    sl3 = next_sl(sl3, 3);
    hist_rd[1] = hist_rd[0];
    hist_rw[1] = hist_rw[0];
    hist_rd[0] = int'(rd_ex);
    hist_rw[0] = rw_ex;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      e = exp_q.pop_front();
      check("dut1_cycle", act1, e[17:9]);
      check("dut3_cycle", act3, e[8:0]);
    end
  end

  initial begin
    model_clear();
    reset = 1'b0;
    set_in(5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("reset_dut1", act1, RESET_WORD);
    check("reset_dut3", act3, RESET_WORD);
    check_bit("reset_state3", if3.fsm_state, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // add x5 then consumers one and two cycles later
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // x5 written in both MEM and WB shadows: MEM wins
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // write to x0 is never forwarded
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // lw x7 with consumer in ID, bubble, consumer reaches EX
    drive(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // taken branch coinciding with a load-use hazard
    drive(5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);
    // back-to-back load-use pairs
    drive(5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);

    // reset during the second stall cycle of the 3-cycle instance
    drive(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    set_in(5'd0, 5'd7, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({exp_word(sl1), exp_word(sl3)});
    #6;
    reset = 1'b0;
    #1;
    check("midstall_reset_dut1", act1, RESET_WORD);
    check("midstall_reset_dut3", act3, RESET_WORD);
    check_bit("midstall_reset_state3", if3.fsm_state, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
    drive(5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic mr, rw;
      mr = ($urandom_range(0, 3) == 0);
      rw = mr || ($urandom_range(0, 3) != 0);
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), rw, mr,
            ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
